// File: rtl/gen_scheduler.sv
// Game-of-Life generation sequencer for an 8x8 board: one cell per cycle through an external
// rule decoder, double-buffered so the display and outputs only ever see whole generations.
module gen_scheduler #(
  parameter bit          WRAP       = 1'b1,
  parameter int          PERIOD_W   = 16,
  parameter int          GEN_W      = 16,
  parameter logic [63:0] INIT_BOARD = 64'h0000_0000_0007_0402
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_en,
  input  logic [2:0]          load_row,
  input  logic [7:0]          load_data,
  input  logic                step,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  input  logic [5:0]          disp_addr,
  output logic [7:0]          disp_bits,
  output logic                dec_center,
  output logic [7:0]          dec_sides,
  input  logic                dec_nexton,
  output logic                busy,
  output logic                gen_done,
  output logic [GEN_W-1:0]    gen_count,
  output logic                extinct,
  output logic                stable
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          idx_q, idx_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [GEN_W-1:0]    gen_q, gen_d;
  logic [63:0]         cur_q, cur_d;
  logic [63:0]         next_q, next_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ext_q, ext_d;
  logic                stab_q, stab_d;
  logic [2:0]          row_s, col_s;
  logic                disp_col_unused_s;

  // Offsets dr/dc are 2-bit two's complement (-1, 0, +1); the carry bits flag off-board cells.
  function automatic logic neighbour(input logic [63:0] b, input logic [2:0] r,
                                     input logic [2:0] c, input logic [1:0] dr,
                                     input logic [1:0] dc);
    logic [4:0] rr;
    logic [4:0] cc;
    rr = {2'b00, r} + {{3{dr[1]}}, dr};
    cc = {2'b00, c} + {{3{dc[1]}}, dc};
    if (WRAP || ((rr[4:3] == 2'b00) && (cc[4:3] == 2'b00))) begin
      neighbour = b[{rr[2:0], cc[2:0]}];
    end else begin
      neighbour = 1'b0;
    end
  endfunction

  assign row_s             = idx_q[5:3];
  assign col_s             = idx_q[2:0];
  assign disp_bits         = cur_q[{disp_addr[5:3], 3'b000} +: 8];
  assign disp_col_unused_s = ^disp_addr[2:0];

  assign busy      = busy_q;
  assign gen_done  = done_q;
  assign gen_count = gen_q;
  assign extinct   = ext_q;
  assign stable    = stab_q;

  always_comb begin
    dec_center = 1'b0;
    dec_sides  = 8'h00;
    if (state_q == S_EVAL) begin
      dec_center   = cur_q[idx_q];
      dec_sides[0] = neighbour(cur_q, row_s, col_s, 2'b11, 2'b00);
      dec_sides[1] = neighbour(cur_q, row_s, col_s, 2'b11, 2'b01);
      dec_sides[2] = neighbour(cur_q, row_s, col_s, 2'b00, 2'b01);
      dec_sides[3] = neighbour(cur_q, row_s, col_s, 2'b01, 2'b01);
      dec_sides[4] = neighbour(cur_q, row_s, col_s, 2'b01, 2'b00);
      dec_sides[5] = neighbour(cur_q, row_s, col_s, 2'b01, 2'b11);
      dec_sides[6] = neighbour(cur_q, row_s, col_s, 2'b00, 2'b11);
      dec_sides[7] = neighbour(cur_q, row_s, col_s, 2'b11, 2'b11);
    end else begin
      dec_center = 1'b0;
      dec_sides  = 8'h00;
    end
  end

  // In IDLE a load beats a start, and a start beats the free-run timer update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    gen_d   = gen_q;
    cur_d   = cur_q;
    next_d  = next_q;
    ext_d   = ext_q;
    stab_d  = stab_q;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          cur_d[{load_row, 3'b000} +: 8] = load_data;
        end else if (step || (run && (timer_q == {PERIOD_W{1'b0}}))) begin
          idx_d   = 6'd0;
          state_d = S_EVAL;
        end else if (run) begin
          timer_d = timer_q - PERIOD_W'(1'b1);
        end else begin
          timer_d = period;
        end
      end
      S_EVAL: begin
        next_d[idx_q] = dec_nexton;
        if (idx_q == 6'd63) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_COMMIT: begin
        cur_d   = next_q;
        gen_d   = gen_q + GEN_W'(1'b1);
        stab_d  = (next_q == cur_q);
        ext_d   = (next_q == 64'd0);
        timer_d = period;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_COMMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 6'd0;
      timer_q <= period;
      gen_q   <= {GEN_W{1'b0}};
      cur_q   <= INIT_BOARD;
      next_q  <= INIT_BOARD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ext_q   <= 1'b0;
      stab_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      gen_q   <= gen_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ext_q   <= ext_d;
      stab_q  <= stab_d;
    end
  end

endmodule

// File: tb/tb_gen_scheduler.sv
// Scoreboard bench for gen_scheduler: a toroidal and a bounded instance, each driven by a
// behavioural Life rule decoder; expected boards are hand-computed constants.
`timescale 1ns/10ps
module tb_gen_scheduler;

  localparam logic [63:0] INIT    = 64'h0000_0000_0007_0402;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] GLIDE4  = 64'h0000_0000_0E08_0400;
  localparam logic [63:0] CORNER  = 64'h8100_0000_0000_0081;

  typedef struct {
    logic [63:0] board;
    logic        chk_board;
    logic [15:0] gc;
    logic        stable;
    logic        extinct;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [2:0]  load_row = 3'd0;
  logic [7:0]  load_data = 8'h00;
  logic        step = 1'b0;
  logic        step0 = 1'b0;
  logic        run = 1'b0;
  logic [15:0] period = 16'd10;
  logic [5:0]  disp_addr, mon_addr = 6'd0, stim_addr = 6'd0;
  logic        mon_sel = 1'b0;

  logic [7:0]  disp_bits1, disp_bits0, dec_sides1, dec_sides0;
  logic        dec_center1, dec_center0, dec_nexton1, dec_nexton0;
  logic        busy1, busy0, gen_done1, gen_done0;
  logic [15:0] gen_count1, gen_count0;
  logic        extinct1, extinct0, stable1, stable0;

  exp_t q1[$];
  exp_t q0[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   pushed1 = 0, pushed0 = 0, seen1 = 0, seen0 = 0;
  int   cyc = 0;
  bit   spacing_en = 1'b0;

  assign disp_addr = mon_sel ? mon_addr : stim_addr;

  function automatic logic life(input logic c, input logic [7:0] s);
    int n;
    n = $countones(s);
    return c ? ((n == 2) || (n == 3)) : (n == 3);
  endfunction

  assign dec_nexton1 = life(dec_center1, dec_sides1);
  assign dec_nexton0 = life(dec_center0, dec_sides0);

  gen_scheduler #(.WRAP(1'b1), .PERIOD_W(16), .GEN_W(16), .INIT_BOARD(INIT)) u_dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_row(load_row), .load_data(load_data),
    .step(step), .run(run), .period(period), .disp_addr(disp_addr), .disp_bits(disp_bits1),
    .dec_center(dec_center1), .dec_sides(dec_sides1), .dec_nexton(dec_nexton1),
    .busy(busy1), .gen_done(gen_done1), .gen_count(gen_count1), .extinct(extinct1),
    .stable(stable1)
  );

  gen_scheduler #(.WRAP(1'b0), .PERIOD_W(16), .GEN_W(16), .INIT_BOARD(INIT)) u_dut0 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_row(load_row), .load_data(load_data),
    .step(step0), .run(1'b0), .period(period), .disp_addr(disp_addr), .disp_bits(disp_bits0),
    .dec_center(dec_center0), .dec_sides(dec_sides0), .dec_nexton(dec_nexton0),
    .busy(busy0), .gen_done(gen_done0), .gen_count(gen_count0), .extinct(extinct0),
    .stable(stable0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] b, input logic cb, input logic [15:0] gc,
                              input logic st, input logic ex);
    exp_t e;
    e.board = b; e.chk_board = cb; e.gc = gc; e.stable = st; e.extinct = ex;
    return e;
  endfunction

  task automatic push1(input exp_t e);
    q1.push_back(e);
    pushed1++;
  endtask

  task automatic push0(input exp_t e);
    q0.push_back(e);
    pushed0++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load_board(input logic [63:0] b);
    for (int r = 0; r < 8; r++) begin
      load_en = 1'b1; load_row = 3'(r); load_data = b[r*8 +: 8];
      @(posedge clk); #1;
    end
    load_en = 1'b0;
  endtask

  task automatic pulse_step(input bit both);
    step = 1'b1; step0 = both;
    @(posedge clk); #1;
    step = 1'b0; step0 = 1'b0;
  endtask

  task automatic read_board(output logic [63:0] b);
    for (int r = 0; r < 8; r++) begin
      stim_addr = 6'(r * 8);
      #0.1;
      b[r*8 +: 8] = disp_bits1;
    end
  endtask

  task automatic wait_sig(input string nm, input bit want_done);
    bit got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk); #1;
      if (want_done ? gen_done1 : busy1) got = 1'b1;
    end
    chk(nm, 64'(got), 64'd1);
  endtask

  // Monitor: on every gen_done snapshot the displayed boards and retire one expectation.
  initial begin : monitor
    exp_t        e;
    logic [63:0] b1, b0;
    int          last = 0;
    bit          have_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!spacing_en) have_last = 1'b0;
      if (gen_done1 || gen_done0) begin
        mon_sel = 1'b1;
        for (int r = 0; r < 8; r++) begin
          mon_addr = 6'(r * 8);
          #0.1;
          b1[r*8 +: 8] = disp_bits1;
          b0[r*8 +: 8] = disp_bits0;
        end
        mon_sel = 1'b0;
      end
      if (gen_done1) begin
        seen1++;
        if (spacing_en && have_last) chk("w1_gen_done_spacing", 64'(cyc - last), 64'd76);
        last = cyc; have_last = spacing_en;
        chk("w1_expectation_pending", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          if (e.chk_board) chk("w1_board", b1, e.board);
          chk("w1_gen_count", 64'(gen_count1), 64'(e.gc));
          chk("w1_stable", 64'(stable1), 64'(e.stable));
          chk("w1_extinct", 64'(extinct1), 64'(e.extinct));
        end
      end
      if (gen_done0) begin
        seen0++;
        chk("w0_expectation_pending", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          if (e.chk_board) chk("w0_board", b0, e.board);
          chk("w0_gen_count", 64'(gen_count0), 64'(e.gc));
          chk("w0_stable", 64'(stable0), 64'(e.stable));
          chk("w0_extinct", 64'(extinct0), 64'(e.extinct));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [63:0] b;
    int          busy_cnt, done_at;

    // Reset state
    do_reset();
    read_board(b);
    chk("reset_board", b, INIT);
    chk("reset_gen_count", 64'(gen_count1), 64'd0);
    chk("reset_busy", 64'(busy1), 64'd0);
    chk("reset_gen_done", 64'(gen_done1), 64'd0);
    chk("reset_flags", 64'({stable1, extinct1}), 64'd0);
    chk("reset_dec_idle", 64'({dec_center1, dec_sides1}), 64'd0);

    // Blinker: latency of busy/gen_done and two phases
    load_board(BLINK_H);
    push1(mk(BLINK_V, 1'b1, 16'd1, 1'b0, 1'b0));
    pulse_step(1'b0);
    busy_cnt = 0; done_at = 0;
    for (int i = 1; i <= 66; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (busy1) busy_cnt++;
      if (gen_done1 && done_at == 0) done_at = i;
    end
    chk("blinker_busy_cycles", 64'(busy_cnt), 64'd65);
    chk("blinker_gen_done_latency", 64'(done_at), 64'd66);
    repeat (2) @(posedge clk); #1;
    push1(mk(BLINK_H, 1'b1, 16'd2, 1'b0, 1'b0));
    pulse_step(1'b0);
    repeat (67) @(posedge clk); #1;

    // Glider on the torus returns home after 32 generations
    do_reset();
    for (int g = 1; g <= 32; g++) begin
      if (g == 4) push1(mk(GLIDE4, 1'b1, 16'(g), 1'b0, 1'b0));
      else if (g == 32) push1(mk(INIT, 1'b1, 16'(g), 1'b0, 1'b0));
      else push1(mk(64'd0, 1'b0, 16'(g), 1'b0, 1'b0));
      pulse_step(1'b0);
      repeat (67) @(posedge clk); #1;
    end

    // Corner cells: a block when wrapped, isolated cells when bounded
    do_reset();
    load_board(CORNER);
    push1(mk(CORNER, 1'b1, 16'd1, 1'b1, 1'b0));
    push0(mk(64'd0, 1'b1, 16'd1, 1'b0, 1'b1));
    pulse_step(1'b1);
    repeat (67) @(posedge clk); #1;

    // Free run with period 10; loads and steps while busy are dropped
    do_reset();
    load_board(BLINK_H);
    push1(mk(BLINK_V, 1'b1, 16'd1, 1'b0, 1'b0));
    push1(mk(BLINK_H, 1'b1, 16'd2, 1'b0, 1'b0));
    push1(mk(BLINK_V, 1'b1, 16'd3, 1'b0, 1'b0));
    push1(mk(BLINK_H, 1'b1, 16'd4, 1'b0, 1'b0));
    spacing_en = 1'b1;
    run = 1'b1;
    wait_sig("run_gen1_done", 1'b1);
    wait_sig("run_gen2_busy", 1'b0);
    repeat (3) begin
      load_en = 1'b1; load_row = 3'd0; load_data = 8'hFF; step = 1'b1;
      @(posedge clk); #1;
    end
    load_en = 1'b0; step = 1'b0;
    wait_sig("run_gen2_done", 1'b1);
    wait_sig("run_gen3_done", 1'b1);
    wait_sig("run_gen4_busy", 1'b0);
    run = 1'b0;
    pulse_step(1'b0);
    wait_sig("run_gen4_done", 1'b1);
    repeat (300) @(posedge clk); #1;
    spacing_en = 1'b0;

    // Reset in the middle of EVAL abandons the generation
    do_reset();
    load_board(BLINK_H);
    pulse_step(1'b0);
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    read_board(b);
    chk("midreset_board", b, INIT);
    chk("midreset_gen_count", 64'(gen_count1), 64'd0);
    chk("midreset_busy", 64'(busy1), 64'd0);
    chk("midreset_gen_done", 64'(gen_done1), 64'd0);
    repeat (100) @(posedge clk); #1;

    chk("w1_gen_done_total", 64'(seen1), 64'(pushed1));
    chk("w0_gen_done_total", 64'(seen0), 64'(pushed0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
